// File: rtl/mult_pkg.sv
// Shared widths and the round-robin selection helper for the 4-way multiplier arbiter.
package mult_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned P_W   = 16;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } grant_t;

  function automatic grant_t rr_next(input logic [N_REQ-1:0] valid,
                                     input logic [ID_W-1:0]  last);
    grant_t          g;
    logic [ID_W-1:0] idx;
    g = '0;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx = last + ID_W'(k);
      if (valid[idx]) begin
        g.found = 1'b1;
        g.idx   = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/multiplier8.sv
// Combinational unsigned 8x8 multiplier producing a full 16-bit product.
module multiplier8
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [P_W-1:0]  p
);

  assign p = {{(P_W-OP_W){1'b0}}, a} * {{(P_W-OP_W){1'b0}}, b};

endmodule

// File: rtl/mult8_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared 8x8 multiplier.
module mult8_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*OP_W-1:0] req_a,
  input  logic [N_REQ*OP_W-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [P_W-1:0]        rsp_p,
  output logic                  busy
);

  logic            s1_valid;
  logic [OP_W-1:0] s1_a;
  logic [OP_W-1:0] s1_b;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] last_grant;

  logic            s1_en;
  logic            s2_en;
  logic            accept;
  grant_t          grant;
  logic [OP_W-1:0] sel_a;
  logic [OP_W-1:0] sel_b;
  logic [P_W-1:0]  mul_p;

  assign s2_en = !rsp_valid || rsp_ready;
  assign s1_en = !s1_valid || s2_en;
  assign busy  = s1_valid || rsp_valid;

  always_comb begin
    grant     = rr_next(req_valid, last_grant);
    req_ready = '0;
    if (grant.found && s1_en && !rst) begin
      req_ready[grant.idx] = 1'b1;
    end
    accept = |req_ready;
    sel_a  = req_a[grant.idx*OP_W +: OP_W];
    sel_b  = req_b[grant.idx*OP_W +: OP_W];
  end

  multiplier8 u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_p      <= '0;
      rsp_id     <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      if (s2_en) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_p  <= mul_p;
          rsp_id <= s1_id;
        end
      end
      if (s1_en) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= grant.idx;
        end
      end
      if (accept) begin
        last_grant <= grant.idx;
      end
    end
  end

endmodule
